// File: rtl/generic_serial_subtractor_if.sv
// Purpose : operand/result bundle for the bit-serial subtractor (start, s_in, a_in in; busy, done, d_out, borrow out).
// Latency : n/a (wiring only).
// Backpressure: none carried here; the requester watches busy, and start is ignored while busy is high.
interface generic_serial_subtractor_if #(
    parameter int N = 4
);
    logic         start;   // request, honoured only while busy is low
    logic [N:0]   s_in;    // minuend (adder sum)
    logic [N-1:0] a_in;    // subtrahend, zero-extended inside the core
    logic         busy;    // high while bits are being processed
    logic         done;    // one-cycle result strobe
    logic [N:0]   d_out;   // (s_in - a_in) mod 2^(N+1)
    logic         borrow;  // s_in < a_in

    modport master (
        output start, s_in, a_in,
        input  busy, done, d_out, borrow
    );

    modport slave (
        input  start, s_in, a_in,
        output busy, done, d_out, borrow
    );
endinterface

// File: rtl/generic_serial_subtractor.sv
// Purpose : recovers d = s - a one bit per clock (LSB first) with a single full-subtractor cell.
// Latency : start accepted at edge k -> done pulses in the cycle after edge k+N+2; one result per N+2 cycles.
// Backpressure: start is ignored while busy (operand shift registers untouched); a start in the DONE cycle chains back-to-back.
// Ports   : clk, rst_n (async, active-low); bus.slave carries start/s_in/a_in in and busy/done/d_out/borrow out.
module generic_serial_subtractor #(
    parameter int N = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    generic_serial_subtractor_if.slave    bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_DONE
    } state_t;

    state_t       state;
    logic [N:0]   s_sr;
    logic [N:0]   a_sr;
    logic [N:0]   d_sr;
    logic         bw;
    logic [CW-1:0] cnt;

    logic         busy_q;
    logic         done_q;
    logic [N:0]   d_q;
    logic         borrow_q;

    logic         accept;
    logic         diff_bit;
    logic         bw_next;

    // A request is taken in IDLE, and also in DONE so results can stream back-to-back.
    assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));

    // Full-subtractor cell on the current LSB of the operand shift registers.
    assign diff_bit = s_sr[0] ^ a_sr[0] ^ bw;
    assign bw_next  = (~s_sr[0] & a_sr[0]) | (~(s_sr[0] ^ a_sr[0]) & bw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            s_sr     <= '0;
            a_sr     <= '0;
            d_sr     <= '0;
            bw       <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        s_sr   <= bus.s_in;
                        a_sr   <= {1'b0, bus.a_in};
                        d_sr   <= '0;
                        bw     <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_SUB;
                    end
                end
                S_SUB: begin
                    s_sr <= s_sr >> 1;
                    a_sr <= a_sr >> 1;
                    // Difference enters at the MSB so bit 0 lands at d_sr[0] after N+1 shifts.
                    d_sr <= {diff_bit, d_sr[N:1]};
                    bw   <= bw_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N)) begin
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Results publish here only; they stay put through any following operation.
                    done_q   <= 1'b1;
                    d_q      <= d_sr;
                    borrow_q <= bw;
                    if (accept) begin
                        s_sr   <= bus.s_in;
                        a_sr   <= {1'b0, bus.a_in};
                        d_sr   <= '0;
                        bw     <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_SUB;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.d_out  = d_q;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_generic_serial_subtractor.sv
// Purpose : exercises generic_serial_subtractor against an arithmetic reference (s - a mod 2^(N+1), s < a).
// Latency : expects done N+2 cycles after the accepting edge, N+2 apart when chained.
// Backpressure: drives start during busy and checks it is ignored.
module tb_generic_serial_subtractor;
    localparam int N    = 4;
    localparam int MOD  = 1 << (N + 1);
    localparam int LIM  = 20;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    generic_serial_subtractor_if #(.N(N)) bus ();

    generic_serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_diff(input int s, input int a);
        return (s - a + MOD) % MOD;
    endfunction

    function automatic int ref_borrow(input int s, input int a);
        return (s < a) ? 1 : 0;
    endfunction

    // One operation; optionally keeps start high with junk operands for 'hold' cycles after acceptance.
    // lat = cycles from accepting edge to first done sample (0 on timeout).
    task automatic run_op(input int s, input int a, input int hold,
                          output int lat, output int busy_cnt);
        bit found;
        @(negedge clk);
        bus.start = 1'b1;
        bus.s_in  = (N+1)'(s);
        bus.a_in  = N'(a);
        @(posedge clk); #1;
        busy_cnt = int'(bus.busy);
        lat      = 0;
        found    = 1'b0;
        for (int j = 1; j <= LIM && !found; j++) begin
            @(negedge clk);
            bus.start = (j <= hold);
            bus.s_in  = (N+1)'($urandom);
            bus.a_in  = N'($urandom);
            @(posedge clk); #1;
            if (bus.done) begin
                found = 1'b1;
                lat   = j;
            end else begin
                busy_cnt += int'(bus.busy);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int j = 0; j < cycles; j++) begin
            @(posedge clk); #1;
            cnt += int'(bus.done);
        end
    endtask

    task automatic check_op(input string tag, input int s, input int a);
        int lat, bc;
        run_op(s, a, 0, lat, bc);
        check({tag, " latency"}, lat, N + 2);
        check({tag, " d_out"}, bus.d_out, ref_diff(s, a));
        check({tag, " borrow"}, bus.borrow, ref_borrow(s, a));
    endtask

    initial begin
        int lat, bc, cnt, s, a;
        bit found;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.s_in  = '0;
        bus.a_in  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset d_out", bus.d_out, 0);
        check("reset borrow", bus.borrow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        run_op(18, 7, 0, lat, bc);
        check("t1 latency", lat, N + 2);
        check("t1 busy cycles", bc, N + 1);
        check("t1 d_out", bus.d_out, 11);
        check("t1 borrow", bus.borrow, 0);
        check_op("t2a", 3, 9);
        check("t2a d_out const", bus.d_out, 26);
        check_op("t2b", 0, 0);
        check_op("t2c", 31, 15);
        check("t2c d_out const", bus.d_out, 16);

        // start held during SUB with other operands: only the first pair counts
        run_op(20, 6, 3, lat, bc);
        check("t3 latency", lat, N + 2);
        check("t3 busy cycles", bc, N + 1);
        check("t3 d_out", bus.d_out, ref_diff(20, 6));
        check("t3 borrow", bus.borrow, 0);
        count_done(2 * (N + 2), cnt);
        check("t3 extra done", cnt, 0);

        // Back-to-back: second start lands in the DONE cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.s_in  = 5'd25;
        bus.a_in  = 4'd12;
        @(posedge clk); #1;
        cnt = 0;
        for (int j = 1; j <= N + 1; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            @(posedge clk); #1;
            cnt += int'(bus.done);
        end
        check("t4 early done", cnt, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.s_in  = 5'd2;
        bus.a_in  = 4'd13;
        @(posedge clk); #1;
        check("t4 first done", bus.done, 1);
        check("t4 first d_out", bus.d_out, ref_diff(25, 12));
        check("t4 first borrow", bus.borrow, ref_borrow(25, 12));
        check("t4 no gap busy", bus.busy, 1);
        lat   = 0;
        found = 1'b0;
        for (int j = 1; j <= LIM && !found; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            @(posedge clk); #1;
            if (j == 2) check("t4 d_out held", bus.d_out, ref_diff(25, 12));
            if (bus.done) begin
                found = 1'b1;
                lat   = j;
            end
        end
        check("t4 done spacing", lat, N + 2);
        check("t4 second d_out", bus.d_out, ref_diff(2, 13));
        check("t4 second borrow", bus.borrow, ref_borrow(2, 13));

        // Asynchronous reset mid-SUB (d_out currently nonzero)
        @(negedge clk);
        bus.start = 1'b1;
        bus.s_in  = 5'd30;
        bus.a_in  = 4'd1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5 busy async", bus.busy, 0);
        check("t5 done async", bus.done, 0);
        check("t5 d_out async", bus.d_out, 0);
        check("t5 borrow async", bus.borrow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(2 * (N + 2), cnt);
        check("t5 no done after reset", cnt, 0);
        check_op("t5 post reset", 9, 4);

        // Random operands
        for (int i = 0; i < 150; i++) begin
            s = int'($urandom_range(MOD - 1, 0));
            a = int'($urandom_range((1 << N) - 1, 0));
            check_op("rand", s, a);
        end

        // Round trip with the adder: s = a + b must give back b with no borrow
        for (int ai = 0; ai < (1 << N); ai++) begin
            for (int bi = 0; bi < (1 << N); bi++) begin
                run_op(ai + bi, ai, 0, lat, bc);
                check("rt latency", lat, N + 2);
                check("rt d_out", bus.d_out, bi);
                check("rt borrow", bus.borrow, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
